// File: rtl/count_sched.sv
`default_nettype none
// ============================================================================
// Module      : count_sched
// Description : Round-robin burst scheduler driving a shared dual counter.
// Revision    : 1.0
// ============================================================================
module count_sched #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NREQ-1:0]         Req,
    input  logic [NREQ-1:0]         ReqSlt,
    input  logic [NREQ*LEN_W-1:0]   ReqLen,
    input  logic                    Pause,
    output logic [NREQ-1:0]         Gnt,
    output logic [NREQ-1:0]         Done,
    output logic                    CntEn,
    output logic                    CntSlt,
    output logic                    Busy
);

    localparam int c_PTR_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [LEN_W:0]       r_rem;
    logic                 r_slt;
    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      r_done;

    logic                 w_any;
    logic                 w_found;
    logic [c_PTR_W-1:0]   w_idx;
    logic [c_PTR_W-1:0]   w_win;
    logic [LEN_W-1:0]     w_sel_len;
    logic [LEN_W:0]       w_win_len;
    logic                 w_cnt_en;
    logic                 w_last;

    assign w_any = |Req;

    // Search upward from the priority pointer, wrapping modulo NREQ.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = r_ptr + c_PTR_W'(k);
            if (!w_found && Req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // A zero length field encodes the maximum burst of 2**LEN_W.
    assign w_sel_len = ReqLen[w_win*LEN_W +: LEN_W];
    assign w_win_len = (w_sel_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_sel_len};

    assign w_cnt_en = (r_state == S_BURST) && !Pause;
    assign w_last   = w_cnt_en && (r_rem == (LEN_W+1)'(1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any)  w_next = S_BURST;
            S_BURST: if (w_last) w_next = S_DONE;
            S_DONE:              w_next = S_IDLE;
            default:             w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_slt   <= 1'b0;
            r_gnt   <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt <= NREQ'(1) << w_win;
                        r_rem <= w_win_len;
                        r_slt <= ReqSlt[w_win];
                        r_ptr <= w_win + c_PTR_W'(1);
                    end
                end
                S_BURST: begin
                    if (w_cnt_en) begin
                        r_rem <= r_rem - (LEN_W+1)'(1);
                    end
                    if (w_last) begin
                        r_gnt  <= '0;
                        r_done <= r_gnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Gnt    = r_gnt;
    assign Done   = r_done;
    assign CntEn  = w_cnt_en;
    assign CntSlt = (r_state == S_BURST) && r_slt;
    assign Busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire
